// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// Latency: n/a (types and default widths only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MASK_W       = 4;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // One latched memory transaction. Field widths follow the package
    // defaults; the arbiter's width parameters are expected to match them.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_MASK_W-1:0] mask;
        logic                  we_re;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_txn_t;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data requesters, with a saturating starvation counter.
// Latency: winner/grant_if are combinational; the counter updates on the clock edge.
// Backpressure: none; the caller decides when a grant is taken via the grant strobe.
//
// Ports: clk, rst (sync, active-low), if_req, dm_req, idle (arbiter in IDLE),
//        grant (a grant is taken this cycle) -> winner (owner_e encoding), grant_if.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT   // must be >= 1
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic idle,
    input  logic grant,
    output logic winner,
    output logic grant_if
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_wins;

    // Data side has priority unless fetch has already been passed over
    // STARVE_LIMIT times in a row.
    assign if_wins  = if_req && (!dm_req || (starve_cnt == CNT_MAX));
    assign winner   = if_wins ? OWN_IF : OWN_DM;
    assign grant_if = grant && if_wins;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant && if_req) begin
            // Data grant taken while fetch waits.
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (idle && !if_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (if_*) and data (dm_*) requesters, data first, fetch starvation bounded.
// Latency: req -> mem_req 1 cycle; mem_valid -> requester valid 1 cycle; at most one transaction per 3 cycles.
// Backpressure: requesters hold req until their valid pulse; memory stalls by withholding mem_valid.
//
// Ports: clk, rst (sync, active-low); if_req/if_addr/if_mask -> if_valid/if_rdata;
//        dm_req/dm_we_re/dm_addr/dm_mask/dm_wdata -> dm_valid/dm_rdata;
//        mem_req/mem_we_re/mem_addr/mem_mask/mem_wdata <- mem_valid/mem_rdata; busy, bus_err.
// Build option: define ARB_TIMEOUT_EN to enable the ACT watchdog (TIMEOUT_CYCLES) and sticky bus_err;
//               without it ACT waits for mem_valid indefinitely and bus_err is tied low.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MASK_W       = DEF_MASK_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [MASK_W-1:0] if_mask,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we_re,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [MASK_W-1:0] dm_mask,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MASK_W-1:0] mem_mask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              bus_err
);

    arb_state_e state;
    owner_e     owner;
    mem_txn_t   txn;

    logic in_idle;
    logic grant;
    logic pick_winner;
    logic pick_grant_if;

    assign in_idle = (state == IDLE);
    assign grant   = in_idle && (if_req || dm_req);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .idle    (in_idle),
        .grant   (grant),
        .winner  (pick_winner),
        .grant_if(pick_grant_if)
    );

    // The memory side is driven straight from the latched transaction, so
    // address/mask/data hold their last values once mem_req drops.
    assign mem_we_re = txn.we_re;
    assign mem_addr  = txn.addr;
    assign mem_mask  = txn.mask;
    assign mem_wdata = txn.wdata;

`ifdef ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            txn      <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt   <= '0;
            bus_err  <= 1'b0;
`endif
        end else begin
            // Valid pulses are raised on entry to RESP and last one cycle.
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= owner_e'(pick_winner);
                        if (pick_grant_if) begin
                            txn <= '{addr: if_addr, mask: if_mask, we_re: 1'b0, wdata: '0};
                        end else begin
                            txn <= '{addr: dm_addr, mask: dm_mask, we_re: dm_we_re, wdata: dm_wdata};
                        end
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ACT;
`ifdef ARB_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                ACT: begin
                    if (mem_valid) begin
                        // Read data is captured for writes too.
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= mem_rdata;
                            dm_valid <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        // Memory never answered: complete with zero data and flag it.
                        mem_req <= 1'b0;
                        state   <= RESP;
                        bus_err <= 1'b1;
                        if (owner == OWN_IF) begin
                            if_rdata <= '0;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= '0;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
